// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and memory-side signal bundle for lsu_mem_ctrl.
//   req_*   : CPU request channel (valid/ready), byte address, store data
//   resp_*  : one-cycle completion pulse with error flag and load data
//   mem_*   : full-word data-memory port; mem_rdata is registered by memory
// Modports:
//   slave  : the LSU itself (accepts requests, drives the memory port)
//   master : the environment (CPU stage plus data memory)
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_byte;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_wdata;
  logic        mem_sb_op;
  logic        mem_lb_op;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_byte, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
           mem_addr, mem_we, mem_re, mem_wdata, mem_sb_op, mem_lb_op
  );

  modport master (
    output req_valid, req_we, req_byte, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           mem_addr, mem_we, mem_re, mem_wdata, mem_sb_op, mem_lb_op
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the execute stage and a word-indexed data memory.
// Accepts LW/SW/LB/SB over valid/ready, uses full-word memory accesses only,
// sign-extends LB lanes, performs read-modify-write for SB and returns a
// one-cycle response pulse.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : lsu_mem_ctrl_if.slave (request, response and memory signals)
module lsu_mem_ctrl #(
  parameter int unsigned WORD_IDX_W      = 8,
  parameter int unsigned ADDR_LIMIT_BITS = 10
) (
  input  logic           clk,
  input  logic           rst,
  lsu_mem_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, LD_RD, LD_CAP, ST_WR, SB_RD, SB_WR
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [WORD_IDX_W+1:0]   r_addr;
  logic                    r_byte;
  logic [31:0]             r_wdata;
  logic                    r_resp_valid;
  logic                    r_resp_err;
  logic [31:0]             r_resp_rdata;

  logic                    w_accept;
  logic                    w_err;
  logic [7:0]              w_byte;
  logic [31:0]             w_load;
  logic [31:0]             w_merge;
  logic                    w_mem_we;
  logic                    w_mem_re;
  logic [31:0]             w_mem_wdata;

  assign bus.req_ready = (r_state == IDLE) && !rst;
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign w_err         = (|bus.req_addr[31:ADDR_LIMIT_BITS]) ||
                         (!bus.req_byte && (|bus.req_addr[1:0]));

  // Lane select for loads and lane merge for byte stores (little-endian).
  always_comb begin
    w_byte = bus.mem_rdata[7:0];
    case (r_addr[1:0])
      2'd0: w_byte = bus.mem_rdata[7:0];
      2'd1: w_byte = bus.mem_rdata[15:8];
      2'd2: w_byte = bus.mem_rdata[23:16];
      2'd3: w_byte = bus.mem_rdata[31:24];
    endcase
    w_load  = r_byte ? {{24{w_byte[7]}}, w_byte} : bus.mem_rdata;
    w_merge = bus.mem_rdata;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r_addr[1:0] == 2'(i)) w_merge[8*i +: 8] = r_wdata[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_mem_we    = 1'b0;
    w_mem_re    = 1'b0;
    w_mem_wdata = '0;
    unique case (r_state)
      IDLE: begin
        if (w_accept && !w_err) begin
          if (!bus.req_we)      w_next = LD_RD;
          else if (bus.req_byte) w_next = SB_RD;
          else                  w_next = ST_WR;
        end
      end
      LD_RD: begin
        w_mem_re = 1'b1;
        w_next   = LD_CAP;
      end
      LD_CAP: w_next = IDLE;
      ST_WR: begin
        w_mem_we    = 1'b1;
        w_mem_wdata = r_wdata;
        w_next      = IDLE;
      end
      SB_RD: begin
        w_mem_re = 1'b1;
        w_next   = SB_WR;
      end
      SB_WR: begin
        w_mem_we    = 1'b1;
        w_mem_wdata = w_merge;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Request capture and response generation; resp_rdata only changes on a
  // completion pulse, so it holds the last load result in between.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= '0;
      r_byte       <= 1'b0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      if (w_accept) begin
        r_addr  <= bus.req_addr[WORD_IDX_W+1:0];
        r_byte  <= bus.req_byte;
        r_wdata <= bus.req_wdata;
        if (w_err) begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b1;
          r_resp_rdata <= '0;
        end
      end
      case (r_state)
        LD_CAP: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= w_load;
        end
        ST_WR, SB_WR: begin
          r_resp_valid <= 1'b1;
          r_resp_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.mem_addr   = {{(32-WORD_IDX_W){1'b0}}, r_addr[WORD_IDX_W+1:2]};
  assign bus.mem_we     = w_mem_we;
  assign bus.mem_re     = w_mem_re;
  assign bus.mem_wdata  = w_mem_wdata;
  assign bus.mem_sb_op  = 1'b0;
  assign bus.mem_lb_op  = 1'b0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed vector table, hand-written
// multi-cycle sequences (back-to-back loads, reset during SB) and random
// operations checked against a byte-arithmetic reference memory.
module tb_lsu_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl #(.WORD_IDX_W(8), .ADDR_LIMIT_BITS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Data memory environment: registered read, held while re is low.
  logic [31:0] env_mem [256] = '{default: '0};
  logic [31:0] mem_rdata_q = '0;
  assign bus.mem_rdata = mem_rdata_q;
  always @(posedge clk) begin
    if (bus.mem_we) env_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    if (bus.mem_re) mem_rdata_q <= env_mem[bus.mem_addr[7:0]];
  end

  // Activity monitor: counts memory accesses and protocol violations.
  int          acc_cnt   = 0;
  int          both_cnt  = 0;
  int          wide_cnt  = 0;
  logic [31:0] last_addr = '0;
  logic        prev_rv   = 1'b0;
  always @(negedge clk) begin
    if (bus.mem_we && bus.mem_re) both_cnt++;
    if (bus.mem_we || bus.mem_re) begin
      acc_cnt++;
      last_addr = bus.mem_addr;
    end
    if (bus.resp_valid && prev_rv) wide_cnt++;
    prev_rv = bus.resp_valid;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference memory: byte-lane arithmetic on whole words.
  logic [31:0] ref_mem [256] = '{default: '0};

  function automatic void ref_op(input logic we, input logic byt,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output int lat, output logic err,
                                 output logic [31:0] rd, output int acc);
    int unsigned w, ln, b, scale;
    w     = addr / 4;
    ln    = addr % 4;
    scale = 32'd1 << (8 * ln);
    err   = (addr >= 32'd1024) || (!byt && ln != 0);
    rd    = '0;
    if (err) begin
      lat = 1; acc = 0;
      return;
    end
    b = (ref_mem[w] / scale) % 256;
    if (we && !byt) begin
      ref_mem[w] = wdata;
      lat = 2; acc = 1;
    end else if (we) begin
      ref_mem[w] = ref_mem[w] - b * scale + (wdata % 256) * scale;
      lat = 3; acc = 2;
    end else if (!byt) begin
      rd = ref_mem[w];
      lat = 3; acc = 1;
    end else begin
      rd = (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
      lat = 3; acc = 1;
    end
  endfunction

  // One request: wait for ready, present for one edge, then find the pulse.
  task automatic do_req(input logic we, input logic byt, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic err,
                        output logic [31:0] rd);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_byte  = byt;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = -1; err = 1'bx; rd = 'x;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = c; err = bus.resp_err; rd = bus.resp_rdata;
        break;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic        byt;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          acc;
  } vec_t;

  vec_t tv [22];

  initial begin
    int          lat, rlat, acc, racc, a0, acc_seen, nresp;
    logic        err, rerr, saw;
    logic [31:0] rd, rrd, addr, wdata;
    logic        we, byt;
    logic [31:0] exp_q [$];
    int          mism;

    tv[0]  = '{1'b1, 1'b0, 32'h10,       32'hDEADBEEF, 2, 1'b0, 32'h0,        1};
    tv[1]  = '{1'b0, 1'b0, 32'h10,       32'h0,        3, 1'b0, 32'hDEADBEEF, 1};
    tv[2]  = '{1'b1, 1'b0, 32'h20,       32'h11223344, 2, 1'b0, 32'h0,        1};
    tv[3]  = '{1'b1, 1'b1, 32'h22,       32'h000000AB, 3, 1'b0, 32'h0,        2};
    tv[4]  = '{1'b0, 1'b0, 32'h20,       32'h0,        3, 1'b0, 32'h11AB3344, 1};
    tv[5]  = '{1'b1, 1'b0, 32'h30,       32'h7F8000FF, 2, 1'b0, 32'h0,        1};
    tv[6]  = '{1'b0, 1'b1, 32'h31,       32'h0,        3, 1'b0, 32'h00000000, 1};
    tv[7]  = '{1'b0, 1'b1, 32'h32,       32'h0,        3, 1'b0, 32'hFFFFFF80, 1};
    tv[8]  = '{1'b0, 1'b1, 32'h33,       32'h0,        3, 1'b0, 32'h0000007F, 1};
    tv[9]  = '{1'b0, 1'b1, 32'h30,       32'h0,        3, 1'b0, 32'hFFFFFFFF, 1};
    tv[10] = '{1'b0, 1'b0, 32'h06,       32'h0,        1, 1'b1, 32'h0,        0};
    tv[11] = '{1'b1, 1'b0, 32'h400,      32'hCAFEF00D, 1, 1'b1, 32'h0,        0};
    tv[12] = '{1'b0, 1'b0, 32'h3FC,      32'h0,        3, 1'b0, 32'h0,        1};
    tv[13] = '{1'b1, 1'b1, 32'h3FF,      32'hFFFFFF5A, 3, 1'b0, 32'h0,        2};
    tv[14] = '{1'b0, 1'b0, 32'h3FC,      32'h0,        3, 1'b0, 32'h5A000000, 1};
    tv[15] = '{1'b0, 1'b1, 32'h3FF,      32'h0,        3, 1'b0, 32'h0000005A, 1};
    tv[16] = '{1'b1, 1'b0, 32'h02,       32'h55555555, 1, 1'b1, 32'h0,        0};
    tv[17] = '{1'b0, 1'b1, 32'h401,      32'h0,        1, 1'b1, 32'h0,        0};
    tv[18] = '{1'b0, 1'b0, 32'h80000000, 32'h0,        1, 1'b1, 32'h0,        0};
    tv[19] = '{1'b1, 1'b1, 32'h3C01,     32'h00000011, 1, 1'b1, 32'h0,        0};
    tv[20] = '{1'b0, 1'b0, 32'h10,       32'h0,        3, 1'b0, 32'hDEADBEEF, 1};
    tv[21] = '{1'b0, 1'b0, 32'h00,       32'h0,        3, 1'b0, 32'h0,        1};

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_byte  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset state.
    #1 rst = 1'b1;
    #2;
    check("rst_req_ready",  32'(bus.req_ready),  32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_err",   32'(bus.resp_err),   32'd0);
    check("rst_resp_rdata", bus.resp_rdata,      32'd0);
    check("rst_mem_we_re",  {30'd0, bus.mem_we, bus.mem_re}, 32'd0);
    check("rst_mem_addr",   bus.mem_addr,        32'd0);
    check("rst_mem_wdata",  bus.mem_wdata,       32'd0);
    check("tied_sb_lb_op",  {30'd0, bus.mem_sb_op, bus.mem_lb_op}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 check("post_rst_ready", 32'(bus.req_ready), 32'd1);

    // Directed vector table.
    for (int i = 0; i < 22; i++) begin
      ref_op(tv[i].we, tv[i].byt, tv[i].addr, tv[i].wdata, rlat, rerr, rrd, racc);
      a0 = acc_cnt;
      do_req(tv[i].we, tv[i].byt, tv[i].addr, tv[i].wdata, lat, err, rd);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tv[i].lat));
      check($sformatf("vec%0d_err", i),     32'(err), 32'(tv[i].err));
      check($sformatf("vec%0d_rdata", i),   rd,       tv[i].rdata);
      check($sformatf("vec%0d_mem_accesses", i), 32'(acc_cnt - a0), 32'(tv[i].acc));
      if (!tv[i].err)
        check($sformatf("vec%0d_mem_addr", i), last_addr, {22'd0, tv[i].addr[9:2]});
    end

    // resp_rdata holds the last load result while idle.
    ref_op(1'b0, 1'b0, 32'h10, 32'h0, rlat, rerr, rrd, racc);
    do_req(1'b0, 1'b0, 32'h10, 32'h0, lat, err, rd);
    repeat (3) @(negedge clk);
    check("rdata_hold", bus.resp_rdata, 32'hDEADBEEF);

    // req_valid held high across three loads with a changing address.
    a0 = acc_cnt; acc_seen = 0; nresp = 0;
    @(negedge clk);
    for (int c = 0; c < 40 && nresp < 3; c++) begin
      if (bus.resp_valid) begin
        rrd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0BAD0;
        check($sformatf("b2b_rdata%0d", nresp), bus.resp_rdata, rrd);
        nresp++;
      end
      if (acc_seen < 3) begin
        addr = 32'h10 + 32'h10 * 32'(c % 4);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_byte  = 1'b0;
        bus.req_addr  = addr;
        if (bus.req_ready) begin
          ref_op(1'b0, 1'b0, addr, 32'h0, rlat, rerr, rrd, racc);
          exp_q.push_back(rrd);
          acc_seen++;
        end
      end else begin
        bus.req_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    check("b2b_responses", 32'(nresp), 32'd3);
    check("b2b_acceptances", 32'(acc_cnt - a0), 32'd3);

    // Reset asserted while an SB sits in SB_RD.
    ref_op(1'b1, 1'b0, 32'h40, 32'h12345678, rlat, rerr, rrd, racc);
    do_req(1'b1, 1'b0, 32'h40, 32'h12345678, lat, err, rd);
    a0 = acc_cnt;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_byte  = 1'b1;
    bus.req_addr  = 32'h41;
    bus.req_wdata = 32'h000000CC;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("abort_mem_we_re", {30'd0, bus.mem_we, bus.mem_re}, 32'd0);
    check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 check("abort_ready_after", 32'(bus.req_ready), 32'd1);
    saw = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.resp_valid) saw = 1'b1;
    end
    check("abort_no_resp", 32'(saw), 32'd0);
    check("abort_no_access", 32'(acc_cnt - a0), 32'd0);
    check("abort_rdata_cleared", bus.resp_rdata, 32'd0);
    ref_op(1'b0, 1'b0, 32'h40, 32'h0, rlat, rerr, rrd, racc);
    do_req(1'b0, 1'b0, 32'h40, 32'h0, lat, err, rd);
    check("abort_word_unchanged", rd, 32'h12345678);

    // Random operations against the reference memory.
    for (int i = 0; i < 80; i++) begin
      int unsigned r;
      r   = $urandom_range(0, 15);
      we  = 1'($urandom_range(0, 1));
      byt = 1'($urandom_range(0, 1));
      wdata = $urandom;
      if (r == 0)      addr = (32'($urandom_range(1, 4194303)) << 10) | 32'($urandom_range(0, 1023));
      else if (r == 1) addr = 32'($urandom_range(0, 1023));
      else             addr = 32'($urandom_range(0, 63));
      if (!byt && r < 12) addr = addr & ~32'd3;
      ref_op(we, byt, addr, wdata, rlat, rerr, rrd, racc);
      a0 = acc_cnt;
      do_req(we, byt, addr, wdata, lat, err, rd);
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(rlat));
      check($sformatf("rnd%0d_err", i),     32'(err), 32'(rerr));
      check($sformatf("rnd%0d_rdata", i),   rd,       rrd);
      check($sformatf("rnd%0d_accesses", i), 32'(acc_cnt - a0), 32'(racc));
    end

    mism = 0;
    for (int w = 0; w < 256; w++) if (env_mem[w] !== ref_mem[w]) mism++;
    check("final_memory_words_differing", 32'(mism), 32'd0);
    check("we_re_both_high_cycles", 32'(both_cnt), 32'd0);
    check("resp_pulse_wider_than_1", 32'(wide_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
